msf_bit_decoder: RTL and testbench
==================================

# msf_bit_decoder

Consumes the one-second framing produced by the MSF timing-control stage (`one_sec_marker`, `second_counter`) together with the raw `msf_carrier_pulse` stream. It measures carrier presence in five 100 ms windows after every second marker, classifies the MSF A/B data bits and the 500 ms minute marker, and assembles a complete 60-bit minute frame. It sits directly downstream of timing control and feeds the time/date register block.

## Interface
- `CLK_HZ`, 12_500_000: clock frequency; window length = CLK_HZ/10 clocks.
- `WIN_W`, 21: width of the window clock counter; must hold CLK_HZ/10-1.
- `clk` in 1: system clock (80 ns).
- `aresetn` in 1: reset, asynchronous, active-low.
- `msf_carrier_pulse` in 1: one-cycle pulse per detected carrier cycle.
- `one_sec_marker` in 1: one-cycle pulse at the start of each second.
- `second_counter` in 6: second index 0..59 (0..60 on leap-second minutes), valid with `one_sec_marker`.
- `carrier_threshold` in 17: pulses per window at or above which the window counts as carrier ON.
- `bit_a`, `bit_b` out 1: decoded bits for the last second; 1 = carrier OFF in that window.
- `bit_second` out 6: second index the bits belong to.
- `bit_valid` out 1: one-cycle strobe; `bit_a`, `bit_b` and `bit_second` are stable from this cycle until the next strobe.
- `minute_marker` out 1: one-cycle strobe, 500 ms OFF detected.
- `frame_a`, `frame_b` out 60: assembled A/B bits, bit n = second n.
- `frame_valid` out 1: one-cycle strobe, frame outputs updated.
- `sync_error` out 1: one-cycle strobe on a framing violation.

## Operation
- States: IDLE, MEASURE, CLASSIFY.
- IDLE: on `one_sec_marker`, latch `second_counter`, clear the window, pulse and window-index counters, and go to MEASURE.
- MEASURE: the window clock counts 0..CLK_HZ/10-1 while carrier pulses are counted (17-bit, saturating).
  - At window end, store `off[w]` = (pulse count < threshold), clear the pulse count and increment w.
  - After w = 4 ends, go to CLASSIFY.
- CLASSIFY (one cycle):
  - `off[0..4]` all 1: pulse `minute_marker`, then run the frame logic.
  - `off[0]` = 0: pulse `sync_error` and emit no bit.
  - Otherwise: `bit_a` = `off[1]`, `bit_b` = `off[2]`, `bit_second` = latched second. Pulse `bit_valid` and write bit position `bit_second` of the working A/B shift registers. A second index above 59 writes nothing.
  - Return to IDLE.
- Frame logic on `minute_marker`:
  - If the bits-written counter is 59 or 60, copy the working registers to `frame_a`/`frame_b` and pulse `frame_valid`.
  - Otherwise pulse `sync_error` instead.
  - In both cases clear the working registers and the bit counter.
- A `one_sec_marker` during MEASURE pulses `sync_error` and restarts measurement with the new second; the partial second is discarded.
- A `one_sec_marker` in the CLASSIFY cycle: classification completes and the marker is honoured (transition straight to MEASURE).

## Timing
- Reset values: all outputs 0, state IDLE, all counters 0.
- Strobes come out exactly one cycle after the CLASSIFY cycle. CLASSIFY is entered on the cycle after window 4 ends.
- This gives a marker→`bit_valid` latency of 5·CLK_HZ/10 + 2 cycles.
- `frame_valid` is coincident with `minute_marker`.
- A carrier pulse on the exact window-end cycle is counted in the ending window.
- A threshold of 0 forces every window ON: no bits set, no minute marker.

## Structure
- Shared package `msf_pkg`:
  - state enum;
  - constants `MSF_WINDOWS` = 5, `MSF_FRAME_BITS` = 60, `MSF_BIT_A_WIN` = 1, `MSF_BIT_B_WIN` = 2.
- One sub-module, `msf_window_counter`: window clock, carrier pulse counter and threshold compare, producing `win_end` and `win_off`.

## Test plan
- CLK_HZ = 1000, threshold 50, carrier pulse every 1 cycle; marker with `second_counter` = 17, carrier off in windows 0–1 only.
  - Expect `bit_valid` at 502 cycles with `bit_a` = 1, `bit_b` = 0, `bit_second` = 17.
- Carrier off for windows 0–4.
  - Expect `minute_marker`; `frame_valid` stays 0 and `sync_error` = 1, because no bits have been collected.
- Full minute, seconds 1..59 with A = second[0] and B = 0, then a marker second.
  - Expect `frame_valid` with `frame_a` = 60'hAAA…A (odd bits set) and `frame_b` = 0.
- Second `one_sec_marker` 300 cycles into MEASURE.
  - Expect `sync_error` pulse, no `bit_valid` for the first second, and a correct bit for the second one.
- Carrier ON in window 0.
  - Expect `sync_error` and no `bit_valid`.
- Reset asserted mid-MEASURE.
  - Expect all outputs 0 immediately and no strobe until the next marker plus 502 cycles.

Source files
------------

// File: rtl/msf_pkg.sv
// msf_pkg: state type and framing constants shared by the MSF bit decoder and
// its window counter.
package msf_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MEASURE  = 2'd1,
        ST_CLASSIFY = 2'd2
    } msf_state_t;

    localparam int MSF_WINDOWS    = 5;
    localparam int MSF_FRAME_BITS = 60;
    localparam int MSF_BIT_A_WIN  = 1;
    localparam int MSF_BIT_B_WIN  = 2;

endpackage

// File: rtl/msf_window_counter.sv
// msf_window_counter: 100 ms window clock plus saturating carrier pulse count,
// reporting each window end and whether the carrier was OFF in that window.
module msf_window_counter #(
    parameter int CLK_HZ = 12_500_000,
    parameter int WIN_W  = 21
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        enable,
    input  logic        clear,
    input  logic        carrier_pulse,
    input  logic [16:0] threshold,
    output logic        win_end,
    output logic        win_off
);

    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(CLK_HZ / 10 - 1);

    logic [WIN_W-1:0] clk_cnt_p0;
    logic [16:0]      pulse_cnt_p0;
    logic [16:0]      pulse_next;
    logic             at_last;

    function automatic logic [16:0] pulse_sat_inc(input logic [16:0] v);
        return (&v) ? v : v + 17'd1;
    endfunction

    // The pulse arriving on the window-end cycle still belongs to the ending window.
    assign pulse_next = carrier_pulse ? pulse_sat_inc(pulse_cnt_p0) : pulse_cnt_p0;
    assign at_last    = (clk_cnt_p0 == WIN_LAST);
    assign win_end    = enable && !clear && at_last;
    assign win_off    = (pulse_next < threshold);

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            clk_cnt_p0   <= '0;
            pulse_cnt_p0 <= '0;
        end else if (clear) begin
            clk_cnt_p0   <= '0;
            pulse_cnt_p0 <= '0;
        end else if (enable) begin
            if (at_last) begin
                clk_cnt_p0   <= '0;
                pulse_cnt_p0 <= '0;
            end else begin
                clk_cnt_p0   <= clk_cnt_p0 + 1'b1;
                pulse_cnt_p0 <= pulse_next;
            end
        end
    end

endmodule

// File: rtl/msf_bit_decoder.sv
// msf_bit_decoder: classifies MSF A/B bits and the 500 ms minute marker from five
// carrier windows per second, and assembles the 60-bit A/B minute frame.
module msf_bit_decoder
    import msf_pkg::*;
#(
    parameter int CLK_HZ = 12_500_000,
    parameter int WIN_W  = 21
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        msf_carrier_pulse,
    input  logic        one_sec_marker,
    input  logic [5:0]  second_counter,
    input  logic [16:0] carrier_threshold,
    output logic        bit_a,
    output logic        bit_b,
    output logic [5:0]  bit_second,
    output logic        bit_valid,
    output logic        minute_marker,
    output logic [59:0] frame_a,
    output logic [59:0] frame_b,
    output logic        frame_valid,
    output logic        sync_error
);

    localparam logic [2:0] LAST_WIN  = 3'(MSF_WINDOWS - 1);
    localparam logic [5:0] LAST_SEC  = 6'(MSF_FRAME_BITS - 1);
    localparam logic [6:0] FRAME_MIN = 7'(MSF_FRAME_BITS - 1);
    localparam logic [6:0] FRAME_MAX = 7'(MSF_FRAME_BITS);

    msf_state_t  state;
    msf_state_t  state_nxt;

    logic        win_clear;
    logic        win_enable;
    logic        win_end;
    logic        win_off;

    logic [5:0]  sec_p0;
    logic [2:0]  win_idx_p0;
    logic [4:0]  off_p0;

    logic [59:0] work_a;
    logic [59:0] work_b;
    logic [6:0]  bits_written;

    logic        cls_bit;
    logic        cls_minute;
    logic        cls_bad_start;
    logic        marker_err;
    logic        frame_ok;
    logic        bit_wr;

    function automatic logic [6:0] bits_sat_inc(input logic [6:0] v);
        return (&v) ? v : v + 7'd1;
    endfunction

    assign win_enable = (state == ST_MEASURE);
    assign frame_ok   = (bits_written == FRAME_MIN) || (bits_written == FRAME_MAX);
    assign bit_wr     = cls_bit && (sec_p0 <= LAST_SEC);

    msf_window_counter #(
        .CLK_HZ (CLK_HZ),
        .WIN_W  (WIN_W)
    ) u_window (
        .clk           (clk),
        .aresetn       (aresetn),
        .enable        (win_enable),
        .clear         (win_clear),
        .carrier_pulse (msf_carrier_pulse),
        .threshold     (carrier_threshold),
        .win_end       (win_end),
        .win_off       (win_off)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        win_clear     = 1'b0;
        cls_bit       = 1'b0;
        cls_minute    = 1'b0;
        cls_bad_start = 1'b0;
        marker_err    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (one_sec_marker) begin
                    state_nxt = ST_MEASURE;
                    win_clear = 1'b1;
                end
            end
            ST_MEASURE: begin
                // A marker inside a measurement abandons the partial second.
                if (one_sec_marker) begin
                    win_clear  = 1'b1;
                    marker_err = 1'b1;
                end else if (win_end && (win_idx_p0 == LAST_WIN)) begin
                    state_nxt = ST_CLASSIFY;
                end
            end
            ST_CLASSIFY: begin
                if (&off_p0) begin
                    cls_minute = 1'b1;
                end else if (!off_p0[0]) begin
                    cls_bad_start = 1'b1;
                end else begin
                    cls_bit = 1'b1;
                end
                if (one_sec_marker) begin
                    state_nxt = ST_MEASURE;
                    win_clear = 1'b1;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Measurement stage: latched second and per-window OFF flags.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            sec_p0     <= '0;
            win_idx_p0 <= '0;
            off_p0     <= '0;
        end else if (win_clear) begin
            sec_p0     <= second_counter;
            win_idx_p0 <= '0;
            off_p0     <= '0;
        end else if (win_end) begin
            off_p0[win_idx_p0] <= win_off;
            win_idx_p0         <= win_idx_p0 + 3'd1;
        end
    end

    // Frame assembly: working registers indexed by second.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            work_a       <= '0;
            work_b       <= '0;
            bits_written <= '0;
        end else if (cls_minute) begin
            work_a       <= '0;
            work_b       <= '0;
            bits_written <= '0;
        end else if (bit_wr) begin
            work_a[sec_p0] <= off_p0[MSF_BIT_A_WIN];
            work_b[sec_p0] <= off_p0[MSF_BIT_B_WIN];
            bits_written   <= bits_sat_inc(bits_written);
        end
    end

    // Output stage: strobes one cycle after CLASSIFY, data held until the next strobe.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            bit_a         <= 1'b0;
            bit_b         <= 1'b0;
            bit_second    <= '0;
            bit_valid     <= 1'b0;
            minute_marker <= 1'b0;
            frame_a       <= '0;
            frame_b       <= '0;
            frame_valid   <= 1'b0;
            sync_error    <= 1'b0;
        end else begin
            bit_valid     <= cls_bit;
            minute_marker <= cls_minute;
            frame_valid   <= cls_minute && frame_ok;
            sync_error    <= cls_bad_start || marker_err || (cls_minute && !frame_ok);
            if (cls_bit) begin
                bit_a      <= off_p0[MSF_BIT_A_WIN];
                bit_b      <= off_p0[MSF_BIT_B_WIN];
                bit_second <= sec_p0;
            end
            if (cls_minute && frame_ok) begin
                frame_a <= work_a;
                frame_b <= work_b;
            end
        end
    end

endmodule

// File: tb/tb_msf_bit_decoder.sv
// Bench for msf_bit_decoder: per-window pulse counts drive the carrier, and a
// per-second model of the decoding rules predicts every strobe and frame.
module tb_msf_bit_decoder;

    localparam int CLK_HZ = 1000;
    localparam int WIN    = CLK_HZ / 10;
    localparam int LAT    = 5 * WIN + 2;
    localparam int K_BIT = 0, K_FRAME = 1, K_MINERR = 2, K_STARTERR = 3;

    logic        clk = 1'b0;
    logic        aresetn = 1'b1;
    logic        msf_carrier_pulse = 1'b0;
    logic        one_sec_marker = 1'b0;
    logic [5:0]  second_counter = '0;
    logic [16:0] carrier_threshold = 17'd50;
    logic        bit_a, bit_b, bit_valid, minute_marker, frame_valid, sync_error;
    logic [5:0]  bit_second;
    logic [59:0] frame_a, frame_b;

    msf_bit_decoder #(.CLK_HZ(CLK_HZ), .WIN_W(7)) dut (
        .clk               (clk),
        .aresetn           (aresetn),
        .msf_carrier_pulse (msf_carrier_pulse),
        .one_sec_marker    (one_sec_marker),
        .second_counter    (second_counter),
        .carrier_threshold (carrier_threshold),
        .bit_a             (bit_a),
        .bit_b             (bit_b),
        .bit_second        (bit_second),
        .bit_valid         (bit_valid),
        .minute_marker     (minute_marker),
        .frame_a           (frame_a),
        .frame_b           (frame_b),
        .frame_valid       (frame_valid),
        .sync_error        (sync_error)
    );

    always #40 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe monitor
    int n_bv = 0, n_mm = 0, n_fv = 0, n_se = 0;
    int t_bv = -1, t_bv_prev = -1, t_mm = -1, t_fv = -1, t_se = -1;
    logic bv_a = 0, bv_b = 0;
    logic [5:0] bv_sec = 0, bv_sec_prev = 0;
    logic [59:0] fa = 0, fb = 0;

    always @(negedge clk) begin
        if (bit_valid) begin
            n_bv <= n_bv + 1; t_bv <= cyc; t_bv_prev <= t_bv;
            bv_a <= bit_a; bv_b <= bit_b; bv_sec <= bit_second; bv_sec_prev <= bv_sec;
        end
        if (minute_marker) begin n_mm <= n_mm + 1; t_mm <= cyc; end
        if (frame_valid) begin n_fv <= n_fv + 1; t_fv <= cyc; fa <= frame_a; fb <= frame_b; end
        if (sync_error) begin n_se <= n_se + 1; t_se <= cyc; end
    end

    int n_tests = 0, n_fail = 0;
    int pcount[5];
    int mark;
    int s_bv, s_mm, s_fv, s_se;

    // Reference model state
    int m_bits = 0;
    logic [59:0] m_a = '0, m_b = '0;
    int e_kind;
    logic e_a, e_b;
    logic [59:0] e_fa, e_fb;

    task automatic model_second(input logic [5:0] sec);
        logic [4:0] off;
        for (int w = 0; w < 5; w++) off[w] = (pcount[w] < int'(carrier_threshold));
        if (off == 5'b11111) begin
            if (m_bits == 59 || m_bits == 60) begin
                e_kind = K_FRAME; e_fa = m_a; e_fb = m_b;
            end else begin
                e_kind = K_MINERR;
            end
            m_bits = 0; m_a = '0; m_b = '0;
        end else if (!off[0]) begin
            e_kind = K_STARTERR;
        end else begin
            e_kind = K_BIT; e_a = off[1]; e_b = off[2];
            if (sec < 60) begin
                m_a[sec] = off[1]; m_b[sec] = off[2]; m_bits++;
            end
        end
    endtask

    task automatic snap();
        s_bv = n_bv; s_mm = n_mm; s_fv = n_fv; s_se = n_se;
    endtask

    task automatic set_counts(input int c0, input int c1, input int c2, input int c3, input int c4);
        pcount[0] = c0; pcount[1] = c1; pcount[2] = c2; pcount[3] = c3; pcount[4] = c4;
    endtask

    task automatic drive_second(input logic [5:0] sec, input int len);
        @(posedge clk); #1;
        one_sec_marker = 1'b1;
        second_counter = sec;
        msf_carrier_pulse = 1'($urandom_range(0, 1));
        mark = cyc;
        for (int i = 1; i <= len; i++) begin
            @(posedge clk); #1;
            one_sec_marker = 1'b0;
            second_counter = 6'($urandom_range(0, 63));
            if (i <= 5 * WIN)
                msf_carrier_pulse = (((i - 1) % WIN) >= (WIN - pcount[(i - 1) / WIN]));
            else
                msf_carrier_pulse = 1'($urandom_range(0, 1));
        end
        @(negedge clk); #1;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({bit_a, bit_b, bit_second, bit_valid, minute_marker} !== 10'd0) begin
            n_fail++; $display("FAIL reset_bits: got %b want 0", {bit_a, bit_b, bit_second, bit_valid, minute_marker});
        end
        n_tests++;
        if ({frame_a, frame_b, frame_valid, sync_error} !== 122'd0) begin
            n_fail++; $display("FAIL reset_frame: got %h/%h/%b/%b want 0", frame_a, frame_b, frame_valid, sync_error);
        end
        aresetn = 1'b1;
        snap();
        repeat (20) @(posedge clk);
        #1;
        n_tests++;
        if ((n_bv + n_mm + n_fv + n_se) !== (s_bv + s_mm + s_fv + s_se)) begin
            n_fail++; $display("FAIL reset_idle_strobes: got %0d strobes want 0", n_bv + n_mm + n_fv + n_se - s_bv - s_mm - s_fv - s_se);
        end
    endtask

    task automatic test_minute_no_bits();
        set_counts(0, 0, 0, 0, 0);
        snap(); model_second(6'd0); drive_second(6'd0, LAT);
        n_tests++;
        if (n_mm - s_mm !== 1 || t_mm !== mark + LAT) begin
            n_fail++; $display("FAIL minute_marker: got n=%0d t=%0d want n=1 t=%0d", n_mm - s_mm, t_mm, mark + LAT);
        end
        n_tests++;
        if (n_fv - s_fv !== 0) begin
            n_fail++; $display("FAIL minute_nofv: got %0d frame strobes want 0", n_fv - s_fv);
        end
        n_tests++;
        if (n_se - s_se !== 1 || t_se !== mark + LAT) begin
            n_fail++; $display("FAIL minute_syncerr: got n=%0d t=%0d want n=1 t=%0d", n_se - s_se, t_se, mark + LAT);
        end
    endtask

    task automatic test_basic();
        set_counts(0, 0, 100, 100, 100);
        snap(); model_second(6'd17); drive_second(6'd17, LAT);
        n_tests++;
        if (n_bv - s_bv !== 1 || t_bv !== mark + LAT) begin
            n_fail++; $display("FAIL basic_latency: got n=%0d t=%0d want n=1 t=%0d", n_bv - s_bv, t_bv, mark + LAT);
        end
        n_tests++;
        if ({bv_a, bv_b, bv_sec} !== {1'b1, 1'b0, 6'd17}) begin
            n_fail++; $display("FAIL basic_bits: got a=%b b=%b s=%0d want a=1 b=0 s=17", bv_a, bv_b, bv_sec);
        end
        n_tests++;
        if (n_se - s_se !== 0 || n_mm - s_mm !== 0) begin
            n_fail++; $display("FAIL basic_extra: got se=%0d mm=%0d want 0", n_se - s_se, n_mm - s_mm);
        end
    endtask

    task automatic test_window0_on();
        set_counts(100, 0, 0, 100, 100);
        snap(); model_second(6'd9); drive_second(6'd9, LAT);
        n_tests++;
        if (n_se - s_se !== 1 || t_se !== mark + LAT || n_bv - s_bv !== 0) begin
            n_fail++; $display("FAIL window0_on: got se=%0d t=%0d bv=%0d want se=1 t=%0d bv=0", n_se - s_se, t_se, n_bv - s_bv, mark + LAT);
        end
    endtask

    task automatic test_threshold_zero();
        carrier_threshold = 17'd0;
        set_counts(0, 0, 0, 0, 0);
        snap(); model_second(6'd10); drive_second(6'd10, LAT);
        n_tests++;
        if (n_se - s_se !== 1 || n_bv - s_bv !== 0 || n_mm - s_mm !== 0) begin
            n_fail++; $display("FAIL thr_zero: got se=%0d bv=%0d mm=%0d want 1/0/0", n_se - s_se, n_bv - s_bv, n_mm - s_mm);
        end
        carrier_threshold = 17'd50;
    endtask

    task automatic test_window_end_pulse();
        carrier_threshold = 17'd1;
        set_counts(0, 1, 0, 1, 1);
        snap(); model_second(6'd11); drive_second(6'd11, LAT);
        n_tests++;
        if (n_bv - s_bv !== 1 || {bv_a, bv_b, bv_sec} !== {1'b0, 1'b1, 6'd11}) begin
            n_fail++; $display("FAIL win_end_pulse: got n=%0d a=%b b=%b s=%0d want n=1 a=0 b=1 s=11", n_bv - s_bv, bv_a, bv_b, bv_sec);
        end
        carrier_threshold = 17'd50;
    endtask

    task automatic test_marker_mid_measure();
        set_counts(0, 100, 0, 100, 100);
        snap();
        drive_second(6'd5, 299);
        model_second(6'd6); drive_second(6'd6, LAT);
        n_tests++;
        if (n_se - s_se !== 1 || t_se !== mark + 1) begin
            n_fail++; $display("FAIL mid_marker_err: got n=%0d t=%0d want n=1 t=%0d", n_se - s_se, t_se, mark + 1);
        end
        n_tests++;
        if (n_bv - s_bv !== 1 || t_bv !== mark + LAT || {bv_a, bv_b, bv_sec} !== {1'b0, 1'b1, 6'd6}) begin
            n_fail++; $display("FAIL mid_marker_bit: got n=%0d t=%0d s=%0d want n=1 t=%0d s=6", n_bv - s_bv, t_bv, bv_sec, mark + LAT);
        end
    endtask

    task automatic test_marker_in_classify();
        int m1;
        set_counts(0, 0, 0, 100, 100);
        snap();
        model_second(6'd20); drive_second(6'd20, 5 * WIN);
        m1 = mark;
        set_counts(0, 100, 100, 0, 100);
        model_second(6'd21); drive_second(6'd21, LAT);
        n_tests++;
        if (n_bv - s_bv !== 2 || t_bv_prev !== m1 + LAT || bv_sec_prev !== 6'd20) begin
            n_fail++; $display("FAIL classify_first: got n=%0d t=%0d s=%0d want n=2 t=%0d s=20", n_bv - s_bv, t_bv_prev, bv_sec_prev, m1 + LAT);
        end
        n_tests++;
        if (t_bv !== mark + LAT || {bv_a, bv_b, bv_sec} !== {1'b0, 1'b0, 6'd21} || n_se - s_se !== 0) begin
            n_fail++; $display("FAIL classify_second: got t=%0d a=%b b=%b s=%0d se=%0d want t=%0d 0/0/21 se=0", t_bv, bv_a, bv_b, bv_sec, n_se - s_se, mark + LAT);
        end
    endtask

    task automatic test_random();
        logic [5:0] sec;
        for (int n = 0; n < 20; n++) begin
            carrier_threshold = ($urandom_range(0, 9) == 0) ? 17'd0 : 17'($urandom_range(1, 100));
            for (int w = 0; w < 5; w++) begin
                case ($urandom_range(0, 4))
                    0: pcount[w] = 0;
                    1: pcount[w] = (carrier_threshold > 0) ? int'(carrier_threshold) - 1 : 0;
                    2: pcount[w] = int'(carrier_threshold);
                    3: pcount[w] = 100;
                    default: pcount[w] = $urandom_range(0, 100);
                endcase
            end
            if ($urandom_range(0, 2) != 0) pcount[0] = 0;
            sec = 6'($urandom_range(0, 63));
            snap(); model_second(sec); drive_second(sec, LAT);
            n_tests++;
            case (e_kind)
                K_BIT: if (n_bv - s_bv !== 1 || t_bv !== mark + LAT || {bv_a, bv_b, bv_sec} !== {e_a, e_b, sec}
                           || n_se - s_se !== 0 || n_mm - s_mm !== 0) begin
                    n_fail++; $display("FAIL rand_bit[%0d]: got n=%0d t=%0d a=%b b=%b s=%0d want t=%0d a=%b b=%b s=%0d",
                                       n, n_bv - s_bv, t_bv, bv_a, bv_b, bv_sec, mark + LAT, e_a, e_b, sec);
                end
                K_FRAME: if (n_fv - s_fv !== 1 || n_mm - s_mm !== 1 || fa !== e_fa || fb !== e_fb || n_se - s_se !== 0) begin
                    n_fail++; $display("FAIL rand_frame[%0d]: got fv=%0d a=%h b=%h want a=%h b=%h", n, n_fv - s_fv, fa, fb, e_fa, e_fb);
                end
                K_MINERR: if (n_mm - s_mm !== 1 || n_fv - s_fv !== 0 || n_se - s_se !== 1 || t_se !== mark + LAT) begin
                    n_fail++; $display("FAIL rand_minerr[%0d]: got mm=%0d fv=%0d se=%0d want 1/0/1", n, n_mm - s_mm, n_fv - s_fv, n_se - s_se);
                end
                default: if (n_se - s_se !== 1 || t_se !== mark + LAT || n_bv - s_bv !== 0 || n_mm - s_mm !== 0) begin
                    n_fail++; $display("FAIL rand_starterr[%0d]: got se=%0d bv=%0d mm=%0d want 1/0/0", n, n_se - s_se, n_bv - s_bv, n_mm - s_mm);
                end
            endcase
        end
        carrier_threshold = 17'd50;
    endtask

    task automatic test_full_minute();
        set_counts(0, 0, 0, 0, 0);
        model_second(6'd0); drive_second(6'd0, LAT);
        snap();
        for (int s = 1; s < 60; s++) begin
            set_counts(0, (s % 2 == 1) ? 0 : 100, 100, 100, 100);
            model_second(6'(s)); drive_second(6'(s), LAT);
        end
        n_tests++;
        if (n_bv - s_bv !== 59 || n_se - s_se !== 0) begin
            n_fail++; $display("FAIL minute_bits: got bv=%0d se=%0d want 59/0", n_bv - s_bv, n_se - s_se);
        end
        set_counts(0, 0, 0, 0, 0);
        snap(); model_second(6'd0); drive_second(6'd0, LAT);
        n_tests++;
        if (n_fv - s_fv !== 1 || t_fv !== mark + LAT || t_mm !== t_fv || n_se - s_se !== 0) begin
            n_fail++; $display("FAIL frame_strobe: got fv=%0d t=%0d mm_t=%0d se=%0d want 1 t=%0d", n_fv - s_fv, t_fv, t_mm, n_se - s_se, mark + LAT);
        end
        n_tests++;
        if (fa !== 60'hAAAAAAAAAAAAAAA || fb !== 60'h0) begin
            n_fail++; $display("FAIL frame_data: got a=%h b=%h want a=aaaaaaaaaaaaaaa b=0", fa, fb);
        end
    endtask

    task automatic test_reset_mid();
        set_counts(0, 100, 100, 0, 0);
        @(posedge clk); #1;
        one_sec_marker = 1'b1; second_counter = 6'd40;
        @(posedge clk); #1;
        one_sec_marker = 1'b0;
        repeat (200) @(posedge clk);
        #1;
        aresetn = 1'b0;
        #1;
        n_tests++;
        if ({bit_a, bit_b, bit_second, bit_valid, minute_marker, frame_a, frame_b, frame_valid, sync_error} !== 132'd0) begin
            n_fail++; $display("FAIL reset_mid_outputs: got s=%0d a=%b fa=%h want all 0", bit_second, bit_a, frame_a);
        end
        repeat (3) @(posedge clk);
        #1;
        aresetn = 1'b1;
        m_bits = 0; m_a = '0; m_b = '0;
        snap();
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            msf_carrier_pulse = 1'($urandom_range(0, 1));
        end
        n_tests++;
        if ((n_bv + n_mm + n_fv + n_se) !== (s_bv + s_mm + s_fv + s_se)) begin
            n_fail++; $display("FAIL reset_mid_quiet: got %0d strobes want 0", n_bv + n_mm + n_fv + n_se - s_bv - s_mm - s_fv - s_se);
        end
        set_counts(0, 0, 100, 100, 100);
        snap(); model_second(6'd33); drive_second(6'd33, LAT);
        n_tests++;
        if (n_bv - s_bv !== 1 || t_bv !== mark + LAT || {bv_a, bv_b, bv_sec} !== {1'b1, 1'b0, 6'd33}) begin
            n_fail++; $display("FAIL reset_mid_resume: got n=%0d t=%0d s=%0d want n=1 t=%0d s=33", n_bv - s_bv, t_bv, bv_sec, mark + LAT);
        end
    endtask

    initial begin
        #5 aresetn = 1'b0;
        test_reset();
        test_minute_no_bits();
        test_basic();
        test_window0_on();
        test_threshold_zero();
        test_window_end_pulse();
        test_marker_mid_measure();
        test_marker_in_classify();
        test_random();
        test_full_minute();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
